// File: rtl/matmul_lane_engine.sv
// matmul_lane_engine: LANES-row parallel integer matrix multiply C = A*B over a single-port read/write memory handshake
module matmul_lane_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int DIM_W  = 8,
  parameter int LANES  = 4,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [ADDR_W-1:0] cfg_base_a,
  input  logic [ADDR_W-1:0] cfg_base_b,
  input  logic [ADDR_W-1:0] cfg_base_c,
  input  logic              cfg_signed,
  input  logic [5:0]        cfg_shift,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int LW = $clog2(LANES + 1);
  localparam int IW = DIM_W + LW;
  localparam int XW = LANES > 1 ? $clog2(LANES) : 1;
  typedef enum logic [2:0] {IDLE, CHECK, LOAD_A, LOAD_B, MAC, WRITE, FIN} state_t;
  state_t state;
  logic [DIM_W-1:0]  m_q, k_q, n_q, k, j;
  logic [IW-1:0]     i, row;
  logic [LW-1:0]     l;
  logic [XW-1:0]     x;
  logic [ADDR_W-1:0] base_a, base_b, base_c, a_addr, b_addr, c_addr;
  logic              sgn, err_f, lane_on;
  logic [5:0]        shift;
  logic [DATA_W-1:0] a_q [LANES];
  logic [DATA_W-1:0] b_q, sat_v;
  logic [ACC_W-1:0]  acc [LANES];
  logic [ACC_W-1:0]  acc_x, su;
  logic signed [ACC_W-1:0] ss;

  function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v, input logic s);
    return s ? {{(ACC_W-DATA_W){v[DATA_W-1]}}, v} : {{(ACC_W-DATA_W){1'b0}}, v};
  endfunction

  // l walks the lanes of the current row block; rows past M are masked
  always_comb begin
    row     = i + IW'(l);
    lane_on = (l < LW'(LANES)) && (row < IW'(m_q));
    x       = XW'(l);
    acc_x   = acc[x];
    ss      = $signed(acc_x) >>> shift;
    su      = acc_x >> shift;
    sat_v   = sgn ? ((&ss[ACC_W-1:DATA_W-1] || ~|ss[ACC_W-1:DATA_W-1]) ? ss[DATA_W-1:0]
                     : {ss[ACC_W-1], {(DATA_W-1){~ss[ACC_W-1]}}})
                  : (|su[ACC_W-1:DATA_W] ? '1 : su[DATA_W-1:0]);
    a_addr  = base_a + ADDR_W'(row) * ADDR_W'(k_q) + ADDR_W'(k);
    b_addr  = base_b + ADDR_W'(k) * ADDR_W'(n_q) + ADDR_W'(j);
    c_addr  = base_c + ADDR_W'(row) * ADDR_W'(n_q) + ADDR_W'(j);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_f   <= 1'b0;
      rd_req  <= 1'b0;
      rd_addr <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      i       <= '0;
      j       <= '0;
      k       <= '0;
      l       <= '0;
      for (int q = 0; q < LANES; q++) acc[q] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          m_q    <= cfg_m;
          k_q    <= cfg_k;
          n_q    <= cfg_n;
          base_a <= cfg_base_a;
          base_b <= cfg_base_b;
          base_c <= cfg_base_c;
          sgn    <= cfg_signed;
          shift  <= cfg_shift;
          busy   <= 1'b1;
          state  <= CHECK;
        end
        CHECK: if (m_q == '0 || k_q == '0 || n_q == '0) begin
          err_f <= 1'b1;
          state <= FIN;
        end else begin
          err_f <= 1'b0;
          i     <= '0;
          j     <= '0;
          k     <= '0;
          l     <= '0;
          for (int q = 0; q < LANES; q++) acc[q] <= '0;
          state <= LOAD_A;
        end
        LOAD_A: if (rd_req) begin
          if (rd_valid) begin
            a_q[x] <= rd_data;
            rd_req <= 1'b0;
            l      <= l + 1'b1;
          end
        end else if (lane_on) begin
          rd_req  <= 1'b1;
          rd_addr <= a_addr;
        end else state <= LOAD_B;
        LOAD_B: if (rd_req) begin
          if (rd_valid) begin
            b_q    <= rd_data;
            rd_req <= 1'b0;
            state  <= MAC;
          end
        end else begin
          rd_req  <= 1'b1;
          rd_addr <= b_addr;
        end
        MAC: begin
          for (int q = 0; q < LANES; q++)
            if (i + IW'(q) < IW'(m_q)) acc[q] <= acc[q] + ext(a_q[q], sgn) * ext(b_q, sgn);
          l     <= '0;
          k     <= (k == k_q - 1'b1) ? '0 : k + 1'b1;
          state <= (k == k_q - 1'b1) ? WRITE : LOAD_A;
        end
        WRITE: if (wr_en) begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            l     <= l + 1'b1;
          end
        end else if (lane_on) begin
          wr_en   <= 1'b1;
          wr_addr <= c_addr;
          wr_data <= sat_v;
        end else begin
          for (int q = 0; q < LANES; q++) acc[q] <= '0;
          l <= '0;
          if (j == n_q - 1'b1) begin
            j     <= '0;
            i     <= i + IW'(LANES);
            state <= (i + IW'(LANES) >= IW'(m_q)) ? FIN : LOAD_A;
          end else begin
            j     <= j + 1'b1;
            state <= LOAD_A;
          end
        end
        FIN: begin
          done  <= 1'b1;
          err   <= err_f;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matmul_lane_engine.sv
// tb_matmul_lane_engine: randomized jobs against a plain-arithmetic matrix model with a stalling memory responder
module tb_matmul_lane_engine;
  logic clk = 1'b0, reset, start;
  logic [7:0] cfg_m, cfg_k, cfg_n;
  logic [15:0] cfg_base_a, cfg_base_b, cfg_base_c;
  logic cfg_signed;
  logic [5:0] cfg_shift;
  logic rd_req, rd_valid, wr_en, wr_ready, busy, done, err;
  logic [15:0] rd_addr, rd_data, wr_addr, wr_data;
  int checks = 0, failures = 0;
  logic [15:0] mem [65536];
  int ga [16][16];
  int gb [16][16];
  int wq_a[$], wq_d[$];
  int rcnt, stall_max = 0, rstall = 0, wstall = 0;
  bit wr_block = 0;
  logic rst_seen = 1'b0;

  matmul_lane_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
    .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_base_c(cfg_base_c),
    .cfg_signed(cfg_signed), .cfg_shift(cfg_shift),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rst_seen <= reset;

  // memory responder with random stalls; also watches handshake stability
  initial begin
    logic prev_rp, prev_wp;
    logic [15:0] prev_ra, prev_wa, prev_wd;
    prev_rp = 0; prev_wp = 0; prev_ra = 0; prev_wa = 0; prev_wd = 0;
    rd_valid = 0; rd_data = 0; wr_ready = 0;
    forever begin
      @(posedge clk); #1;
      rd_valid = 0; wr_ready = 0;
      if (!rst_seen) begin
        if (prev_rp) begin
          checks++;
          if (!rd_req || rd_addr !== prev_ra) begin
            failures++; $display("FAIL rd_stable got req=%b addr=%h want req=1 addr=%h", rd_req, rd_addr, prev_ra);
          end
        end
        if (prev_wp) begin
          checks++;
          if (!wr_en || wr_addr !== prev_wa || wr_data !== prev_wd) begin
            failures++; $display("FAIL wr_stable got en=%b addr=%h data=%h want en=1 addr=%h data=%h", wr_en, wr_addr, wr_data, prev_wa, prev_wd);
          end
        end
        if (rd_req && wr_en) begin
          checks++; failures++; $display("FAIL rd_wr_exclusive got both=1 want 0");
        end
      end
      if (rd_req) begin
        if (rstall == 0) begin
          rd_valid = 1; rd_data = mem[rd_addr]; rcnt++;
          rstall = $urandom_range(0, stall_max);
        end else rstall--;
      end else if (stall_max > 0 && $urandom_range(0, 3) == 0) begin
        rd_valid = 1; rd_data = 16'($urandom);
      end
      if (wr_en && !wr_block) begin
        if (wstall == 0) begin
          wr_ready = 1; wq_a.push_back(int'(wr_addr)); wq_d.push_back(int'(wr_data));
          wstall = $urandom_range(0, stall_max);
        end else wstall--;
      end
      prev_rp = rd_req && !rd_valid; prev_ra = rd_addr;
      prev_wp = wr_en && !wr_ready; prev_wa = wr_addr; prev_wd = wr_data;
    end
  end

  function automatic longint val(input int v, input bit s);
    logic [15:0] t;
    t = v[15:0];
    return s ? longint'($signed(t)) : longint'(t);
  endfunction

  task automatic run_job(input int m, k, n, input bit s, input int sh, input int ba, bb, bc,
                         input bit pulse, input bit fill);
    int ex_a[$], ex_d[$];
    int exp_reads, cyc, nw;
    bit got, e;
    longint sum, v;
    if (fill)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin ga[r][c] = int'($urandom_range(0, 65535)); gb[r][c] = int'($urandom_range(0, 65535)); end
    for (int r = 0; r < m; r++) for (int c = 0; c < k; c++) mem[16'(ba + r * k + c)] = 16'(ga[r][c]);
    for (int r = 0; r < k; r++) for (int c = 0; c < n; c++) mem[16'(bb + r * n + c)] = 16'(gb[r][c]);
    exp_reads = 0;
    for (int ib = 0; ib < m; ib += 4) begin
      int act;
      act = (m - ib < 4) ? m - ib : 4;
      exp_reads += n * k * (act + 1);
      for (int c = 0; c < n; c++)
        for (int ln = 0; ln < act; ln++) begin
          sum = 0;
          for (int q = 0; q < k; q++) sum += val(ga[ib + ln][q], s) * val(gb[q][c], s);
          v = sum >>> sh;
          if (s) v = v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
          else v = v > 65535 ? 65535 : v;
          ex_a.push_back((bc + (ib + ln) * n + c) & 65535);
          ex_d.push_back(int'(v) & 65535);
        end
    end
    wq_a.delete(); wq_d.delete(); rcnt = 0;
    cfg_m = 8'(m); cfg_k = 8'(k); cfg_n = 8'(n); cfg_signed = s; cfg_shift = 6'(sh);
    cfg_base_a = 16'(ba); cfg_base_b = 16'(bb); cfg_base_c = 16'(bc);
    start = 1; cyc = 0; got = 0; e = 0;
    while (cyc < 20000 && !got) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", busy); end
      end
      if (done) begin got = 1; e = err; start = 0; end
      else if (pulse && $urandom_range(0, 2) == 0) begin
        start = 1; cfg_m = 8'($urandom); cfg_k = 8'($urandom); cfg_n = 8'($urandom);
        cfg_base_c = 16'($urandom); cfg_signed = 1'($urandom); cfg_shift = 6'($urandom);
      end else start = 0;
    end
    start = 0;
    checks++;
    if (!got) begin failures++; $display("FAIL job_done_timeout got=none want=done m=%0d k=%0d n=%0d", m, k, n); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL job_err got=%b want=0", e); end
    checks++;
    if (wq_a.size() != ex_a.size()) begin failures++; $display("FAIL write_count got=%0d want=%0d", wq_a.size(), ex_a.size()); end
    checks++;
    if (rcnt != exp_reads) begin failures++; $display("FAIL read_count got=%0d want=%0d", rcnt, exp_reads); end
    nw = wq_a.size() < ex_a.size() ? wq_a.size() : ex_a.size();
    for (int w = 0; w < nw; w++) begin
      checks++;
      if (wq_a[w] != ex_a[w] || wq_d[w] != ex_d[w]) begin
        failures++; $display("FAIL c_write[%0d] got addr=%h data=%h want addr=%h data=%h", w, wq_a[w], wq_d[w], ex_a[w], ex_d[w]);
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done got done=%b busy=%b want 0 0", done, busy); end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({busy, done, err, rd_req, wr_en} !== 5'b0) begin
      failures++; $display("FAIL %s_ctrl got=%b want=00000", tag, {busy, done, err, rd_req, wr_en});
    end
    checks++;
    if (rd_addr !== 16'h0 || wr_addr !== 16'h0 || wr_data !== 16'h0) begin
      failures++; $display("FAIL %s_bus got rd_addr=%h wr_addr=%h wr_data=%h want 0", tag, rd_addr, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 0;
    cfg_m = 0; cfg_k = 0; cfg_n = 0; cfg_signed = 0; cfg_shift = 0;
    cfg_base_a = 0; cfg_base_b = 0; cfg_base_c = 0;
    repeat (3) @(posedge clk); #1;
    check_reset_outputs("reset");
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int want[4] = '{19, 22, 43, 50};
    int off;
    ga[0][0] = 1; ga[0][1] = 2; ga[1][0] = 3; ga[1][1] = 4;
    gb[0][0] = 5; gb[0][1] = 6; gb[1][0] = 7; gb[1][1] = 8;
    run_job(2, 2, 2, 0, 0, 100, 200, 300, 0, 0);
    foreach (wq_a[w]) begin
      off = wq_a[w] - 300;
      checks++;
      if (off < 0 || off > 3) begin failures++; $display("FAIL basic_addr got=%0d want=300..303", wq_a[w]); end
      else if (wq_d[w] != want[off]) begin failures++; $display("FAIL basic_c[%0d] got=%0d want=%0d", off, wq_d[w], want[off]); end
    end
  endtask

  task automatic test_masked_rows();
    run_job(5, 3, 2, 0, 0, 1000, 2000, 3000, 0, 1);
    run_job(5, 3, 2, 1, 4, 1000, 2000, 3000, 0, 1);
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin ga[r][c] = 32768; gb[r][c] = 32768; end
    run_job(2, 4, 1, 1, 0, 500, 600, 700, 0, 0);
    checks++;
    if (wq_d.size() == 0 || wq_d[0] != 32767) begin failures++; $display("FAIL sat_max got=%0d want=32767", wq_d.size() ? wq_d[0] : -1); end
    run_job(2, 4, 1, 1, 20, 500, 600, 700, 0, 0);
    checks++;
    if (wq_d.size() == 0 || wq_d[0] != 4096) begin failures++; $display("FAIL sat_shift20 got=%0d want=4096", wq_d.size() ? wq_d[0] : -1); end
  endtask

  task automatic test_zero_dim();
    int busy_cyc, done_cnt, acc_cnt;
    bit err_at_done;
    busy_cyc = 0; done_cnt = 0; acc_cnt = 0; err_at_done = 0;
    cfg_m = 3; cfg_k = 0; cfg_n = 2; start = 1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      start = 0;
      if (busy) busy_cyc++;
      if (rd_req || wr_en) acc_cnt++;
      if (done) begin done_cnt++; err_at_done = err; end
    end
    checks++;
    if (busy_cyc != 2) begin failures++; $display("FAIL zero_busy_cycles got=%0d want=2", busy_cyc); end
    checks++;
    if (done_cnt != 1 || err_at_done !== 1'b1) begin failures++; $display("FAIL zero_done_err got done=%0d err=%b want 1 1", done_cnt, err_at_done); end
    checks++;
    if (acc_cnt != 0) begin failures++; $display("FAIL zero_mem_access got=%0d want=0", acc_cnt); end
  endtask

  task automatic test_stalls();
    stall_max = 7;
    run_job(6, 3, 3, 1, 3, 40, 900, 1800, 1, 1);
    run_job(4, 2, 4, 0, 2, 77, 300, 5000, 1, 1);
    run_job(9, 2, 2, 1, 10, 65530, 65520, 65534, 1, 1);
    stall_max = 0;
  endtask

  task automatic test_reset_in_write();
    int cyc, dn;
    wr_block = 1;
    cfg_m = 4; cfg_k = 2; cfg_n = 2; cfg_signed = 0; cfg_shift = 0;
    cfg_base_a = 10; cfg_base_b = 20; cfg_base_c = 30;
    start = 1; cyc = 0;
    while (cyc < 2000 && !wr_en) begin @(posedge clk); #1; start = 0; cyc++; end
    checks++;
    if (!wr_en) begin failures++; $display("FAIL rst_write_reach got wr_en=0 want 1"); end
    reset = 1;
    @(posedge clk); #1;
    check_reset_outputs("rst_write");
    reset = 0; dn = 0;
    repeat (6) begin @(posedge clk); #1; if (done || busy) dn++; end
    checks++;
    if (dn != 0) begin failures++; $display("FAIL rst_write_no_done got=%0d want=0", dn); end
    wr_block = 0;
    run_job(4, 2, 2, 0, 0, 10, 20, 30, 0, 1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++)
      run_job(int'($urandom_range(1, 9)), int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
              1'($urandom), int'($urandom_range(0, 18)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)), t[0], 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked_rows();
    test_saturation();
    test_zero_dim();
    test_stalls();
    test_reset_in_write();
    stall_max = 3;
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/matmul_lane_engine.md
MATMUL_LANE_ENGINE -- requirements
Module: matmul_lane_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, operand and result element width in bits.
REQ-002 SHALL have parameter ACC_W, default 40, accumulator width in bits; ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter DIM_W, default 8, width of each dimension field; max dimension is 2^DIM_W-1.
REQ-004 SHALL have parameter LANES, default 4, number of C rows computed in parallel.
REQ-005 SHALL have parameter ADDR_W, default 16, memory word-address width.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 sync active-high reset, sampled on clk rising edge.
REQ-007 SHALL have ports: start in 1 job request; cfg_m, cfg_k, cfg_n in DIM_W each (A is MxK, B is KxN, C is MxN, all row-major).
REQ-008 SHALL have ports: cfg_base_a, cfg_base_b, cfg_base_c in ADDR_W each; cfg_signed in 1; cfg_shift in 6 (right shift applied to the accumulator before narrowing).
REQ-009 SHALL have ports: rd_req out 1; rd_addr out ADDR_W; rd_valid in 1; rd_data in DATA_W.
REQ-010 SHALL have ports: wr_en out 1; wr_addr out ADDR_W; wr_data out DATA_W; wr_ready in 1.
REQ-011 SHALL have ports: busy out 1; done out 1 (pulse); err out 1 (pulse, valid with done).

Function
REQ-012 States SHALL be IDLE, CHECK, LOAD_A, LOAD_B, MAC, WRITE, FIN.
REQ-013 In IDLE, start=1 SHALL latch all cfg_* inputs, set busy=1 on the next cycle, and go to CHECK; cfg_* changes after the latch SHALL have no effect.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 CHECK: if any of M, K, N is 0, the engine SHALL go to FIN with err=1 and issue no memory access; otherwise it SHALL set i=0, j=0, k=0, clear all lane accumulators, and go to LOAD_A.
REQ-016 Read handshake: rd_req and rd_addr SHALL be held stable until a cycle with rd_req=1 and rd_valid=1; rd_data SHALL be captured in that cycle; at most one read SHALL be outstanding; rd_valid while rd_req=0 SHALL be ignored.
REQ-017 LOAD_A SHALL read A[i+l][k] at cfg_base_a + (i+l)*K + k for lanes l = 0..LANES-1 in ascending order, skipping lanes with i+l >= M (masked lanes issue no read).
REQ-018 LOAD_B SHALL read B[k][j] at cfg_base_b + k*N + j, then go to MAC.
REQ-019 MAC SHALL take one cycle: each unmasked lane SHALL add A_l*B to its accumulator, as signed two's complement when cfg_signed=1 and unsigned otherwise, wrapping modulo 2^ACC_W.
REQ-020 After MAC: if k < K-1, then k=k+1 and go to LOAD_A; else k=0 and go to WRITE.
REQ-021 WRITE SHALL emit, per unmasked lane in ascending order, wr_addr = cfg_base_c + (i+l)*N + j and wr_data = sat(acc_l >>> cfg_shift), where the shift is arithmetic when signed and logical when unsigned.
REQ-022 sat() SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1] when signed and to [0, 2^DATA_W-1] when unsigned.
REQ-023 Write handshake: wr_en, wr_addr and wr_data SHALL be held until wr_ready=1 while wr_en=1; each beat SHALL complete in exactly one such cycle.
REQ-024 After the last write: accumulators SHALL clear; if j < N-1, then j=j+1; else j=0 and i=i+LANES, going to FIN if i+LANES >= M; otherwise the engine SHALL go to LOAD_A.
REQ-025 All address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-026 FIN SHALL pulse done=1 for one cycle, drop busy in the same cycle, and return to IDLE; start SHALL be accepted again from the following cycle.
REQ-027 rd_req and wr_en SHALL never both be 1 in the same cycle.

Reset
REQ-028 reset=1 SHALL force IDLE and drive busy=0, done=0, err=0, rd_req=0, wr_en=0, rd_addr=0, wr_addr=0, wr_data=0, and clear accumulators and indices.
REQ-029 reset SHALL take priority over start and over any in-flight handshake; it SHALL abandon the job with no done pulse; outstanding rd_valid/wr_ready after reset SHALL be ignored.

Verification
REQ-030 M=K=N=2, unsigned, shift 0, A=[1 2;3 4], B=[5 6;7 8], zero-wait memory -> C=[19 22;43 50] written at base_c..base_c+3, single done, err=0.
REQ-031 M=5, K=3, N=2, LANES=4 -> exactly 5*2 writes, no reads or writes for rows >= 5, C matches the reference model.
REQ-032 Signed DATA_W=16, K=4, all A=B=-32768 -> acc=2^32, wr_data saturates to 32767; with shift=20, wr_data=4096.
REQ-033 cfg_k=0 with start -> no rd_req or wr_en, done=1 and err=1 in the same cycle, busy high for 2 cycles.
REQ-034 Random rd_valid/wr_ready stalls of 0-7 cycles and start pulses while busy -> results identical to the zero-stall run, addr/data stable during stalls, start pulses ignored.
REQ-035 reset asserted while in WRITE with wr_ready=0 -> all outputs at reset values next cycle, no done; a new job then completes correctly.
